// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter.
//   arb_state_e : arbiter FSM state (idle / an owner holds the push port)
//   STATS_W     : width of each per-requester transfer counter
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin pick: first set bit of valid scanning from base
// upward with wrap-around.
//   valid : request vector
//   base  : starting index of the scan (must be < NUM_REQ)
//   idx   : picked index (0 when nothing is valid)
//   any   : at least one bit of valid is set
module fifo_arb_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned OWNER_W = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [OWNER_W-1:0] base,
    output logic [OWNER_W-1:0] idx,
    output logic               any
);

    localparam int unsigned SUM_W = OWNER_W + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [SUM_W-1:0]     sum;

    // Rotate so bit 0 is the base requester, then take the first set bit.
    always_comb begin
        dbl   = {valid, valid} >> base;
        rot   = dbl[NUM_REQ-1:0];
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, base} + SUM_W'(i);
                if (sum >= SUM_W'(NUM_REQ)) begin
                    sum = sum - SUM_W'(NUM_REQ);
                end
                idx = sum[OWNER_W-1:0];
            end
        end
        any = |valid;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ requesters.
// An owner is locked in for up to MAX_BURST transfers, or until it drops
// valid, then ownership rotates with the old owner at lowest priority.
//   clk, rst         : clock, synchronous active-high reset
//   req_data_i       : packed requester payloads (k at [k*DATA_WIDTH +: DATA_WIDTH])
//   req_valid_i      : requester valid
//   req_grant_o      : requester grant, one-hot or zero
//   data_o, valid_o  : push port into the FIFO
//   grant_i          : FIFO accepts (not full)
//   busy_o           : an owner holds the port
//   owner_o          : current owner index
// Optional (macro FIFO_ARB_STATS_EN):
//   stats_clr_i      : clear all transfer counters (wins over a transfer)
//   stats_cnt_o      : per-requester saturating transfer counts
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8,
    localparam int unsigned OWNER_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_grant_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          grant_i,
    output logic                          busy_o,
    output logic [OWNER_W-1:0]            owner_o
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          stats_clr_i,
    output logic [NUM_REQ*STATS_W-1:0]    stats_cnt_o
`endif
);

    arb_state_e         state, state_nxt;
    logic [OWNER_W-1:0] owner, owner_nxt;
    logic [OWNER_W-1:0] rr_ptr, rr_nxt;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt;

    logic [OWNER_W-1:0] owner_inc;
    logic [OWNER_W-1:0] pick_base;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_any;
    logic               owner_valid;
    logic               xfer_c;
    logic               release_c;

    assign owner_inc   = (owner == OWNER_W'(NUM_REQ - 1)) ? '0 : owner + OWNER_W'(1);
    assign owner_valid = req_valid_i[owner];

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_pick (
        .valid (req_valid_i),
        .base  (pick_base),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    // Next state and push-port outputs
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        cnt_nxt     = beat_cnt;
        pick_base   = rr_ptr;
        valid_o     = 1'b0;
        data_o      = '0;
        req_grant_o = '0;
        xfer_c      = 1'b0;
        release_c   = 1'b0;

        case (state)
            ARB_IDLE: begin
                pick_base = rr_ptr;
                if (pick_any) begin
                    owner_nxt = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = ARB_OWN;
                end
            end
            ARB_OWN: begin
                pick_base          = owner_inc;
                valid_o            = owner_valid;
                data_o             = req_data_i[owner*DATA_WIDTH +: DATA_WIDTH];
                req_grant_o[owner] = grant_i;
                xfer_c             = owner_valid & grant_i;
                // Burst end needs a transfer; a dropped valid ends the packet.
                release_c = (xfer_c && (beat_cnt == CNT_W'(MAX_BURST - 1))) || !owner_valid;
                if (xfer_c && !release_c) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end
                if (release_c) begin
                    rr_nxt = owner_inc;
                    if (pick_any) begin
                        owner_nxt = pick_idx;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase

        // No push may leak out while reset is asserted, even mid-burst.
        if (rst) begin
            valid_o     = 1'b0;
            data_o      = '0;
            req_grant_o = '0;
            xfer_c      = 1'b0;
        end
    end

    assign busy_o  = (state == ARB_OWN);
    assign owner_o = owner;

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] stats_cnt [NUM_REQ];

    // Saturating per-requester transfer counters; clear beats a transfer.
    always_ff @(posedge clk) begin
        if (rst || stats_clr_i) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                stats_cnt[k] <= '0;
            end
        end else if (xfer_c && (stats_cnt[owner] != '1)) begin
            stats_cnt[owner] <= stats_cnt[owner] + STATS_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        assign stats_cnt_o[k*STATS_W +: STATS_W] = stats_cnt[k];
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter (NUM_REQ=4, DATA_WIDTH=32,
// MAX_BURST=8). A per-cycle reference model built from the ownership rules
// is compared against all outputs on every falling edge; directed tests add
// hand-computed checks on ownership order and timing.
// Optional section compiled with FIFO_ARB_STATS_EN.
module tb_fifo_push_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int MB   = 8;

    logic              clk;
    logic              rst;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_grant;
    logic [DW-1:0]     data_o;
    logic              valid_o;
    logic              grant_i;
    logic              busy_o;
    logic [1:0]        owner_o;
`ifdef FIFO_ARB_STATS_EN
    logic              stats_clr;
    logic [NREQ*16-1:0] stats_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fifo_push_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_grant_o (req_grant),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .grant_i     (grant_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr_i (stats_clr),
        .stats_cnt_o (stats_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dval(input int k);
        return 32'hD0D0_0000 + 32'(k) * 32'h111;
    endfunction

    // ---------------- reference model ----------------
    bit m_init = 0;
    bit m_own;
    int m_owner;
    int m_rr;
    int m_beats;
    int xlog[$];

    function automatic int pick(input int base, input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(base + i) % NREQ]) return (base + i) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] e_grant;
        logic [DW-1:0]   e_data;
        logic            e_valid;
        bit              ov, x, rel;
        int              p;
        if (!m_init) begin
            if (rst) begin
                m_init = 1; m_own = 0; m_owner = 0; m_rr = 0; m_beats = 0;
            end
        end else begin
            e_grant = '0;
            e_data  = '0;
            e_valid = 1'b0;
            ov = m_own && req_valid[m_owner];
            x  = ov && grant_i && !rst;
            if (m_own && !rst) begin
                e_valid = ov;
                e_data  = req_data[m_owner*DW +: DW];
                if (grant_i) e_grant[m_owner] = 1'b1;
            end
            check("valid_o", 64'(valid_o), 64'(e_valid));
            check("req_grant_o", 64'(req_grant), 64'(e_grant));
            check("data_o", 64'(data_o), 64'(e_data));
            check("busy_o", 64'(busy_o), 64'(m_own));
            check("owner_o", 64'(owner_o), 64'(m_owner));
            if (x) xlog.push_back(m_owner);
            // advance to the state after the coming rising edge
            if (rst) begin
                m_own = 0; m_owner = 0; m_rr = 0; m_beats = 0;
            end else if (!m_own) begin
                p = pick(m_rr, req_valid);
                if (p >= 0) begin
                    m_own = 1; m_owner = p; m_beats = 0;
                end
            end else begin
                if (x) m_beats++;
                rel = (x && m_beats == MB) || !ov;
                if (rel) begin
                    m_rr = (m_owner + 1) % NREQ;
                    p = pick(m_rr, req_valid);
                    if (p >= 0) begin
                        m_owner = p; m_beats = 0;
                    end else begin
                        m_own = 0;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; grant_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        xlog.delete();
    endtask

    initial begin
        int ok;
        rst = 1'b1;
        req_valid = '0;
        grant_i = 1'b1;
        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = dval(k);
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_owner", 64'(owner_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);

        // single requester 2: 1-cycle latency, back-to-back bursts, no bubble
        do_reset();
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_idle_valid", 64'(valid_o), 64'd0);
        @(negedge clk);
        check("t1_owner", 64'(owner_o), 64'd2);
        check("t1_busy", 64'(busy_o), 64'd1);
        repeat (18) @(negedge clk);
        @(posedge clk); #1;
        check("t1_beats", 64'(xlog.size()), 64'd19);
        ok = 1;
        foreach (xlog[i]) if (xlog[i] != 2) ok = 0;
        check("t1_all_req2", 64'(ok), 64'd1);
        // drop -> rr_ptr=3; then {3,0} valid from idle must pick 3
        req_valid = 4'b0000;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        check("t1_rr_pick3", 64'(owner_o), 64'd3);

        // all valid: fairness 0,1,2,3,0 with 8-beat bursts
        do_reset();
        req_valid = 4'b1111;
        repeat (41) @(negedge clk);
        @(posedge clk); #1;
        check("t2_beats", 64'(xlog.size()), 64'd40);
        ok = 1;
        for (int b = 0; b < 40 && b < xlog.size(); b++)
            if (xlog[b] != (b / MB) % NREQ) ok = 0;
        check("t2_order", 64'(ok), 64'd1);
        if (xlog.size() >= 40) begin
            check("t2_beat8", 64'(xlog[8]), 64'd1);
            check("t2_beat39", 64'(xlog[39]), 64'd0);
        end else begin
            check("t2_short_log", 64'(xlog.size()), 64'd40);
        end

        // owner 1 drops valid after 3 beats while req3 waits
        do_reset();
        req_valid = 4'b1010;
        repeat (4) @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        check("t3_drop_valid", 64'(valid_o), 64'd0);
        @(negedge clk);
        check("t3_owner3", 64'(owner_o), 64'd3);
        check("t3_valid", 64'(valid_o), 64'd1);
        @(posedge clk); #1;
        check("t3_req1_beats", 64'(xlog.size() >= 3 && xlog[0] == 1 && xlog[1] == 1 && xlog[2] == 1 && (xlog.size() == 3 || xlog[3] == 3)), 64'd1);

        // FIFO full for 5 cycles at beat_cnt=4
        do_reset();
        req_valid = 4'b0011;
        repeat (5) @(posedge clk); #1;
        grant_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t4_stall_grant", 64'(req_grant), 64'd0);
            check("t4_stall_data", 64'(data_o), 64'(dval(0)));
            check("t4_stall_valid", 64'(valid_o), 64'd1);
        end
        @(posedge clk); #1;
        grant_i = 1'b1;
        repeat (7) @(negedge clk);
        @(posedge clk); #1;
        check("t4_beats", 64'(xlog.size()), 64'd11);
        ok = (xlog.size() == 11) ? 1 : 0;
        for (int b = 0; b < 8 && b < xlog.size(); b++) if (xlog[b] != 0) ok = 0;
        if (xlog.size() > 8 && xlog[8] != 1) ok = 0;
        check("t4_burst_split", 64'(ok), 64'd1);

        // reset mid-burst on owner 2 after 3 beats
        do_reset();
        req_valid = 4'b1100;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", 64'(valid_o), 64'd0);
        check("t5_rst_grant", 64'(req_grant), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 64'(busy_o), 64'd0);
        check("t5_owner", 64'(owner_o), 64'd0);
        @(posedge clk); #1;
        check("t5_no_push", 64'(xlog.size()), 64'd3);

`ifdef FIFO_ARB_STATS_EN
        // counter saturation and clear-beats-transfer
        do_reset();
        req_valid = 4'b0001;
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        check("st_sat", 64'(stats_cnt[15:0]), 64'hFFFF);
        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(negedge clk);
        check("st_clr_xfer", 64'(valid_o & grant_i), 64'd1);
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        check("st_cleared", 64'(stats_cnt[15:0]), 64'd0);
        @(negedge clk);
        check("st_count1", 64'(stats_cnt[15:0]), 64'd1);
`endif

        req_valid = '0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
